// File: rtl/ptp_frame_parser_if.sv
// -----------------------------------------------------------------------------
// ptp_frame_parser_if
// Bundles the gearbox word stream feeding the PTP frame parser together with
// the parser's descriptor output.
//   ptp_data   [31:0] gearbox word, first received byte in [31:24]
//   ptp_valid         word strobe (one every 4th gmii_clk)
//   ptp_sop           first word of frame, coincident with ptp_valid
//   ptp_eop           last word of frame, coincident with ptp_valid
//   ptp_mod    [1:0]  valid bytes in last word (0 = 4), informational
//   ptp_time   [79:0] RTC timestamp of the current frame's SFD
//   ptp_found         one-cycle pulse, descriptor valid
//   ptp_infor  [91:0] {messageType[3:0], sequenceId[7:0], timestamp[79:0]}
// Modports: master = word source / descriptor sink, slave = parser.
// -----------------------------------------------------------------------------
interface ptp_frame_parser_if;
  logic [31:0] ptp_data;
  logic        ptp_valid;
  logic        ptp_sop;
  logic        ptp_eop;
  logic [1:0]  ptp_mod;
  logic [79:0] ptp_time;
  logic        ptp_found;
  logic [91:0] ptp_infor;

  modport master (
    output ptp_data, ptp_valid, ptp_sop, ptp_eop, ptp_mod, ptp_time,
    input  ptp_found, ptp_infor
  );

  modport slave (
    input  ptp_data, ptp_valid, ptp_sop, ptp_eop, ptp_mod, ptp_time,
    output ptp_found, ptp_infor
  );
endinterface

// File: rtl/ptp_frame_parser.sv
// -----------------------------------------------------------------------------
// ptp_frame_parser
// Recognises PTP event messages in the 32-bit gearbox word stream (L2 Ethernet,
// optionally behind one 802.1Q tag), extracts messageType and sequenceId, and
// emits a one-cycle ptp_found pulse with a 92-bit descriptor
// {messageType, sequenceId[7:0], ptp_time} for the time-stamp FIFO.
// Ports:
//   rst       asynchronous, active-high reset
//   gmii_clk  clock
//   bus       ptp_frame_parser_if.slave (word stream in, descriptor out)
// Optional feature: define PTP_UDP_EN to also parse PTP over IPv4/UDP
// (EtherType 0x0800, UDP destination port 319/320).
// -----------------------------------------------------------------------------
module ptp_frame_parser #(
  parameter logic [15:0] ETYPE_PTP  = 16'h88F7,
  parameter logic [15:0] ETYPE_VLAN = 16'h8100,
  parameter logic [15:0] MSG_MASK   = 16'h000F
) (
  input  logic                rst,
  input  logic                gmii_clk,
  ptp_frame_parser_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, ETYPE, HDR, SEQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic        vlan_q, vlan_d;
  logic        off_q, off_d;
  logic [3:0]  msg_type_q, msg_type_d;
  logic        found_q, found_d;
  logic [91:0] infor_q, infor_d;
  logic [4:0]  seq_word;
  logic [15:0] etype;

`ifdef PTP_UDP_EN
  logic        udp_q, udp_d;
  logic [15:0] udp_port;
  assign udp_port = bus.ptp_data[31:16];
`endif

  // ptp_mod is informational only; low header bytes are only used on the UDP path.
  logic unused_bits;
  assign unused_bits = ^{bus.ptp_mod, bus.ptp_data[15:12], bus.ptp_data[7:0]};

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  assign etype = bus.ptp_data[31:16];

  // Word index of the PTP sequenceId: shifted by one word behind a VLAN tag.
`ifdef PTP_UDP_EN
  assign seq_word = udp_q ? 5'd20 : 5'd13 + {4'd0, off_q};
`else
  assign seq_word = 5'd13 + {4'd0, off_q};
`endif

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    vlan_d     = vlan_q;
    off_d      = off_q;
    msg_type_d = msg_type_q;
    found_d    = 1'b0;
    infor_d    = infor_q;
`ifdef PTP_UDP_EN
    udp_d      = udp_q;
`endif
    if (bus.ptp_valid) begin
      // wcnt_q is the index of the word currently on ptp_data (sop word is 0).
      wcnt_d = bus.ptp_sop ? 5'd1 : sat_inc(wcnt_q);
      if (bus.ptp_sop) begin
        vlan_d  = 1'b0;
        off_d   = 1'b0;
`ifdef PTP_UDP_EN
        udp_d   = 1'b0;
`endif
        // sop together with eop is a runt frame.
        state_d = bus.ptp_eop ? IDLE : ETYPE;
      end else begin
        case (state_q)
          IDLE: ;
          ETYPE: begin
            if (bus.ptp_eop) begin
              state_d = IDLE;
            end else if (wcnt_q == 5'd5) begin
              if (etype == ETYPE_PTP) begin
                msg_type_d = bus.ptp_data[11:8];
                off_d      = 1'b0;
                state_d    = HDR;
              end else if (etype == ETYPE_VLAN) begin
                vlan_d = 1'b1;
`ifdef PTP_UDP_EN
              end else if (etype == 16'h0800) begin
                if (bus.ptp_data[15:8] == 8'h45) udp_d = 1'b1;
                else                             state_d = DONE;
`endif
              end else begin
                state_d = DONE;
              end
            end else if (vlan_q && wcnt_q == 5'd6) begin
              if (etype == ETYPE_PTP) begin
                msg_type_d = bus.ptp_data[11:8];
                off_d      = 1'b1;
                state_d    = HDR;
              end else begin
                state_d = DONE;
              end
`ifdef PTP_UDP_EN
            end else if (udp_q) begin
              if (wcnt_q == 5'd7 && bus.ptp_data[7:0] != 8'd17) begin
                state_d = DONE;
              end else if (wcnt_q == 5'd11 &&
                           udp_port != 16'd319 && udp_port != 16'd320) begin
                state_d = DONE;
              end else if (wcnt_q == 5'd12) begin
                msg_type_d = bus.ptp_data[11:8];
                state_d    = HDR;
              end
`endif
            end
          end
          HDR: begin
            if (bus.ptp_eop)                state_d = IDLE;
            else if (!MSG_MASK[msg_type_q]) state_d = DONE;
            else                            state_d = SEQ;
          end
          SEQ: begin
            // eop on the sequenceId word itself still aborts without a pulse.
            if (bus.ptp_eop) begin
              state_d = IDLE;
            end else if (wcnt_q == seq_word) begin
              found_d = 1'b1;
              infor_d = {msg_type_q, bus.ptp_data[23:16], bus.ptp_time};
              state_d = DONE;
            end
          end
          DONE: if (bus.ptp_eop) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wcnt_q     <= 5'd0;
      vlan_q     <= 1'b0;
      off_q      <= 1'b0;
      msg_type_q <= 4'd0;
      found_q    <= 1'b0;
      infor_q    <= 92'd0;
`ifdef PTP_UDP_EN
      udp_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      vlan_q     <= vlan_d;
      off_q      <= off_d;
      msg_type_q <= msg_type_d;
      found_q    <= found_d;
      infor_q    <= infor_d;
`ifdef PTP_UDP_EN
      udp_q      <= udp_d;
`endif
    end
  end

  assign bus.ptp_found = found_q;
  assign bus.ptp_infor = infor_q;

endmodule
